// File: rtl/reg_to_axi_pkg.sv
// Shared types for the reg-bus to AXI4 bridge: FSM state encoding and the
// reg-bus / AXI4 request and response structs used on the top-level ports.
package reg_to_axi_pkg;

    localparam int unsigned DefAxiAddrWidth = 32;
    localparam int unsigned DefAxiDataWidth = 64;
    localparam int unsigned DefAxiIdWidth   = 4;
    localparam int unsigned DefAxiUserWidth = 1;
    localparam int unsigned DefRegDataWidth = 32;

    localparam logic [1:0] BurstIncr = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WAIT_B,
        ST_READ,
        ST_WAIT_R,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic [DefAxiIdWidth-1:0]   id;
        logic [DefAxiAddrWidth-1:0] addr;
        logic [7:0]                 len;
        logic [2:0]                 size;
        logic [1:0]                 burst;
        logic                       lock;
        logic [3:0]                 cache;
        logic [2:0]                 prot;
        logic [3:0]                 qos;
        logic [3:0]                 region;
        logic [5:0]                 atop;
        logic [DefAxiUserWidth-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [DefAxiDataWidth-1:0]   data;
        logic [DefAxiDataWidth/8-1:0] strb;
        logic                         last;
        logic [DefAxiUserWidth-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [DefAxiIdWidth-1:0]   id;
        logic [1:0]                 resp;
        logic [DefAxiUserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [DefAxiIdWidth-1:0]   id;
        logic [DefAxiAddrWidth-1:0] addr;
        logic [7:0]                 len;
        logic [2:0]                 size;
        logic [1:0]                 burst;
        logic                       lock;
        logic [3:0]                 cache;
        logic [2:0]                 prot;
        logic [3:0]                 qos;
        logic [3:0]                 region;
        logic [DefAxiUserWidth-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [DefAxiIdWidth-1:0]   id;
        logic [DefAxiDataWidth-1:0] data;
        logic [1:0]                 resp;
        logic                       last;
        logic [DefAxiUserWidth-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_rsp_t;

    typedef struct packed {
        logic [DefAxiAddrWidth-1:0]   addr;
        logic                         write;
        logic [DefRegDataWidth-1:0]   wdata;
        logic [DefRegDataWidth/8-1:0] wstrb;
        logic                         valid;
    } reg_req_t;

    typedef struct packed {
        logic [DefRegDataWidth-1:0] rdata;
        logic                       error;
        logic                       ready;
    } reg_rsp_t;

endpackage

// File: rtl/reg_to_axi.sv
// Reg-bus slave to AXI4 master bridge. One access at a time is issued as a
// single-beat INCR burst; write data is replicated across AXI lanes with the
// strobe steered to the addressed lane, and read data is extracted from it.
// All reg-side outputs come from registers, so AXI never reaches reg combinationally.
module reg_to_axi
    import reg_to_axi_pkg::*;
#(
    parameter int unsigned           AxiAddrWidth = DefAxiAddrWidth,
    parameter int unsigned           AxiDataWidth = DefAxiDataWidth,
    parameter int unsigned           AxiIdWidth   = DefAxiIdWidth,
    parameter int unsigned           AxiUserWidth = DefAxiUserWidth,
    parameter int unsigned           RegDataWidth = DefRegDataWidth,
    parameter logic [AxiIdWidth-1:0] AxiId        = '0,
    parameter logic [2:0]            AxiProt      = 3'b000
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  reg_req_t reg_req_i,
    output reg_rsp_t reg_rsp_o,
    output axi_req_t axi_req_o,
    input  axi_rsp_t axi_rsp_i,
    output logic     busy_o
);

    localparam int unsigned RS       = RegDataWidth / 8;
    localparam int unsigned AS       = AxiDataWidth / 8;
    localparam int unsigned NumLanes = AxiDataWidth / RegDataWidth;
    localparam int unsigned RegOffW  = $clog2(RS);
    localparam int unsigned AxiOffW  = $clog2(AS);
    localparam int unsigned LaneW    = AxiOffW - RegOffW;
    localparam int unsigned LaneIdxW = (LaneW > 0) ? LaneW : 1;

    localparam logic [AxiAddrWidth-1:0] AddrMask = ~AxiAddrWidth'(RS - 1);

    state_e                  r_state;
    logic [AxiAddrWidth-1:0] r_addr;
    logic [RegDataWidth-1:0] r_wdata;
    logic [RS-1:0]           r_wstrb;
    logic                    r_write;
    logic [LaneIdxW-1:0]     r_lane;
    logic [RegDataWidth-1:0] r_rdata;
    logic                    r_error;
    logic                    r_reg_ready;
    logic                    r_aw_valid;
    logic                    r_w_valid;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic                    r_b_ready;
    logic                    r_ar_valid;
    logic                    r_r_ready;

    logic [LaneIdxW-1:0]     w_lane;
    logic [AS-1:0]           w_wstrb;
    logic [RegDataWidth-1:0] w_rdata_lane;
    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_unused;

    // Lane index of the incoming request; a single lane needs no address bits.
    if (LaneW > 0) begin : g_lane
        assign w_lane = reg_req_i.addr[AxiOffW-1:RegOffW];
    end else begin : g_nolane
        assign w_lane = '0;
    end

    assign w_aw_hs = r_aw_valid & axi_rsp_i.aw_ready;
    assign w_w_hs  = r_w_valid  & axi_rsp_i.w_ready;

    assign busy_o = (r_state != ST_IDLE);

    // Steer the captured strobe into its lane and pick the read lane from R data.
    always_comb begin
        w_wstrb      = '0;
        w_rdata_lane = '0;
        for (int unsigned i = 0; i < NumLanes; i++) begin
            if (LaneIdxW'(i) == r_lane) begin
                w_wstrb[i*RS +: RS]  = r_wstrb;
                w_rdata_lane         = axi_rsp_i.r.data[i*RegDataWidth +: RegDataWidth];
            end
        end
    end

    // Transaction FSM; every AXI valid/ready and the reg response are registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_write     <= 1'b0;
            r_lane      <= '0;
            r_rdata     <= '0;
            r_error     <= 1'b0;
            r_reg_ready <= 1'b0;
            r_aw_valid  <= 1'b0;
            r_w_valid   <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_b_ready   <= 1'b0;
            r_ar_valid  <= 1'b0;
            r_r_ready   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (reg_req_i.valid) begin
                        r_addr  <= reg_req_i.addr;
                        r_wdata <= reg_req_i.wdata;
                        r_wstrb <= reg_req_i.wstrb;
                        r_write <= reg_req_i.write;
                        r_lane  <= w_lane;
                        if (reg_req_i.write) begin
                            if (reg_req_i.wstrb == '0) begin
                                // Nothing to write: answer locally without AXI traffic.
                                r_rdata     <= '0;
                                r_error     <= 1'b0;
                                r_reg_ready <= 1'b1;
                                r_state     <= ST_RESP;
                            end else begin
                                r_aw_valid <= 1'b1;
                                r_w_valid  <= 1'b1;
                                r_state    <= ST_WRITE;
                            end
                        end else begin
                            r_ar_valid <= 1'b1;
                            r_state    <= ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    // AW and W retire independently; the done flags let either
                    // finish first and the handshake of this cycle counts as done.
                    if (w_aw_hs) begin
                        r_aw_valid <= 1'b0;
                        r_aw_done  <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_w_valid <= 1'b0;
                        r_w_done  <= 1'b1;
                    end
                    if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_b_ready <= 1'b1;
                        r_state   <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (axi_rsp_i.b_valid) begin
                        r_b_ready   <= 1'b0;
                        r_error     <= axi_rsp_i.b.resp[1];
                        r_rdata     <= '0;
                        r_reg_ready <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_READ: begin
                    if (axi_rsp_i.ar_ready) begin
                        r_ar_valid <= 1'b0;
                        r_r_ready  <= 1'b1;
                        r_state    <= ST_WAIT_R;
                    end
                end
                ST_WAIT_R: begin
                    if (axi_rsp_i.r_valid) begin
                        r_r_ready   <= 1'b0;
                        r_rdata     <= w_rdata_lane;
                        r_error     <= axi_rsp_i.r.resp[1];
                        r_reg_ready <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_reg_ready <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Drive AXI channels from the captured request; unused fields stay zero.
    always_comb begin
        axi_req_o = '0;

        axi_req_o.aw.id     = AxiId;
        axi_req_o.aw.addr   = r_addr & AddrMask;
        axi_req_o.aw.len    = 8'd0;
        axi_req_o.aw.size   = 3'(RegOffW);
        axi_req_o.aw.burst  = BurstIncr;
        axi_req_o.aw.prot   = AxiProt;
        axi_req_o.aw.user   = AxiUserWidth'(0);
        axi_req_o.aw_valid  = r_aw_valid;

        axi_req_o.w.data    = {NumLanes{r_wdata}};
        axi_req_o.w.strb    = w_wstrb;
        axi_req_o.w.last    = 1'b1;
        axi_req_o.w.user    = AxiUserWidth'(0);
        axi_req_o.w_valid   = r_w_valid;

        axi_req_o.b_ready   = r_b_ready;

        axi_req_o.ar.id     = AxiId;
        axi_req_o.ar.addr   = r_addr & AddrMask;
        axi_req_o.ar.len    = 8'd0;
        axi_req_o.ar.size   = 3'(RegOffW);
        axi_req_o.ar.burst  = BurstIncr;
        axi_req_o.ar.prot   = AxiProt;
        axi_req_o.ar.user   = AxiUserWidth'(0);
        axi_req_o.ar_valid  = r_ar_valid;

        axi_req_o.r_ready   = r_r_ready;
    end

    // Reg response is only visible in RESP, which is exactly when ready is set.
    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.ready = r_reg_ready;
        reg_rsp_o.rdata = r_reg_ready ? r_rdata : '0;
        reg_rsp_o.error = r_reg_ready & r_error;
    end

    assign w_unused = ^{r_write, axi_rsp_i.b.id, axi_rsp_i.b.user, axi_rsp_i.b.resp[0],
                        axi_rsp_i.r.id, axi_rsp_i.r.last, axi_rsp_i.r.user,
                        axi_rsp_i.r.resp[0]};

endmodule
